// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-back cache controller.
package cache_pkg;

    localparam int ADDR_W         = 27;
    localparam int WORD_W         = 32;
    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = 4;

    typedef logic [LINE_BYTES*8-1:0] mem_data_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } cache_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic              rw;
    } cpu_req_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              ready;
    } cpu_result_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        mem_data_t         data;
        logic              rw;
        logic              valid;
    } mem_req_t;

    // Word 0 occupies the least significant 32 bits of a line.
    function automatic logic [WORD_W-1:0] select_word(mem_data_t line, logic [1:0] sel);
        case (sel)
            2'd0:    return line[31:0];
            2'd1:    return line[63:32];
            2'd2:    return line[95:64];
            default: return line[127:96];
        endcase
    endfunction

    function automatic mem_data_t merge_word(mem_data_t line, logic [1:0] sel,
                                             logic [WORD_W-1:0] word);
        mem_data_t merged;
        merged = line;
        case (sel)
            2'd0:    merged[31:0]   = word;
            2'd1:    merged[63:32]  = word;
            2'd2:    merged[95:64]  = word;
            default: merged[127:96] = word;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU-side and memory-side handshake bundle of the cache controller.
interface dm_cache_ctrl_if;
    import cache_pkg::*;

    logic [ADDR_W-1:0] cpu_req_addr;
    logic [WORD_W-1:0] cpu_req_data;
    logic              cpu_req_rw;
    logic              cpu_req_valid;
    logic [WORD_W-1:0] cpu_res_data;
    logic              cpu_res_ready;

    logic [ADDR_W-1:0] mem_req_addr;
    mem_data_t         mem_req_data;
    logic              mem_req_rw;
    logic              mem_req_valid;
    mem_data_t         mem_res_data;
    logic              mem_res_ready;

    modport slave (
        input  cpu_req_addr, cpu_req_data, cpu_req_rw, cpu_req_valid,
        input  mem_res_data, mem_res_ready,
        output cpu_res_data, cpu_res_ready,
        output mem_req_addr, mem_req_data, mem_req_rw, mem_req_valid
    );

    modport master (
        output cpu_req_addr, cpu_req_data, cpu_req_rw, cpu_req_valid,
        output mem_res_data, mem_res_ready,
        input  cpu_res_data, cpu_res_ready,
        input  mem_req_addr, mem_req_data, mem_req_rw, mem_req_valid
    );

endinterface

// File: rtl/cache_data_array.sv
// Line storage: valid/dirty flags (reset), tag and data (no reset).
// Synchronous write, combinational read on a single shared index.
module cache_data_array
    import cache_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = ADDR_W - INDEX_BITS - 4
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] index,
    input  logic                  wr_en,
    input  logic                  wr_valid,
    input  logic                  wr_dirty,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  mem_data_t             wr_data,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_BITS-1:0]   rd_tag,
    output mem_data_t             rd_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    mem_data_t           data_mem [LINES];

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[index] <= wr_valid;
            dirty_q[index] <= wr_dirty;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            tag_mem[index]  <= wr_tag;
            data_mem[index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_mem[index];
    assign rd_data  = data_mem[index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with 16-byte lines.
//   state      | meaning
//   IDLE       | waiting for a CPU request; latches addr/data/rw
//   COMPARE    | tag check; hit completes, miss picks write-back or fill
//   WRITE_BACK | dirty victim line sent to memory
//   ALLOCATE   | requested line fetched from memory, then re-compare
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic           sys_clk,
    input  logic           rst,
    dm_cache_ctrl_if.slave bus
);

    localparam int TAG_BITS = ADDR_W - INDEX_BITS - 4;

    cache_state_t state;
    cpu_req_t     req_q;
    cpu_result_t  res_q;
    mem_req_t     mem_q;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [1:0]            req_word;
    logic                  unused_addr_lsb;

    logic                  line_valid;
    logic                  line_dirty;
    logic [TAG_BITS-1:0]   line_tag;
    mem_data_t             line_data;

    logic                  wr_en;
    logic                  wr_valid;
    logic                  wr_dirty;
    logic [TAG_BITS-1:0]   wr_tag;
    mem_data_t             wr_data;

    logic                  hit;
    logic                  fill_done;

    assign req_index       = req_q.addr[INDEX_BITS+3:4];
    assign req_tag         = req_q.addr[ADDR_W-1:INDEX_BITS+4];
    assign req_word        = req_q.addr[3:2];
    assign unused_addr_lsb = ^req_q.addr[1:0];

    cache_data_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .index    (req_index),
        .wr_en    (wr_en),
        .wr_valid (wr_valid),
        .wr_dirty (wr_dirty),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data),
        .rd_valid (line_valid),
        .rd_dirty (line_dirty),
        .rd_tag   (line_tag),
        .rd_data  (line_data)
    );

    assign hit       = (state == COMPARE) && line_valid && (line_tag == req_tag);
    assign fill_done = (state == ALLOCATE) && mem_q.valid && bus.mem_res_ready;

    always_comb begin
        wr_en    = 1'b0;
        wr_valid = line_valid;
        wr_dirty = line_dirty;
        wr_tag   = line_tag;
        wr_data  = line_data;
        if (hit && req_q.rw) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            wr_data  = merge_word(line_data, req_word, req_q.data);
        end else if (fill_done) begin
            wr_en    = 1'b1;
            wr_valid = 1'b1;
            wr_dirty = 1'b0;
            wr_tag   = req_tag;
            wr_data  = bus.mem_res_data;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            req_q <= '0;
            res_q <= '0;
            mem_q <= '0;
        end else begin
            res_q <= '0;
            case (state)
                IDLE: begin
                    // The pulse cycle belongs to the finished request; a new one is taken next cycle.
                    if (bus.cpu_req_valid && !res_q.ready) begin
                        req_q <= '{addr: bus.cpu_req_addr,
                                   data: bus.cpu_req_data,
                                   rw:   bus.cpu_req_rw};
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        res_q.ready <= 1'b1;
                        res_q.data  <= req_q.rw ? '0 : select_word(line_data, req_word);
                        state       <= IDLE;
                    end else if (line_valid && line_dirty) begin
                        mem_q <= '{addr:  {line_tag, req_index, 4'b0000},
                                   data:  line_data,
                                   rw:    1'b1,
                                   valid: 1'b1};
                        state <= WRITE_BACK;
                    end else begin
                        mem_q <= '{addr:  {req_tag, req_index, 4'b0000},
                                   data:  '0,
                                   rw:    1'b0,
                                   valid: 1'b1};
                        state <= ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (bus.mem_res_ready) begin
                        mem_q <= '0;
                        state <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    // After a write-back, valid drops for one cycle before the fill is issued.
                    if (!mem_q.valid) begin
                        mem_q <= '{addr:  {req_tag, req_index, 4'b0000},
                                   data:  '0,
                                   rw:    1'b0,
                                   valid: 1'b1};
                    end else if (bus.mem_res_ready) begin
                        mem_q <= '0;
                        state <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_res_data  = res_q.data;
    assign bus.cpu_res_ready = res_q.ready;
    assign bus.mem_req_addr  = mem_q.addr;
    assign bus.mem_req_data  = mem_q.data;
    assign bus.mem_req_rw    = mem_q.rw;
    assign bus.mem_req_valid = mem_q.valid;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: flat-memory reference model, memory responder, decoupled monitors.
module tb_dm_cache_ctrl;

    typedef struct {
        logic [26:0]  addr;
        logic         rw;
        logic [127:0] data;
    } mexp_t;

    logic sys_clk = 1'b0;
    logic rst     = 1'b0;

    dm_cache_ctrl_if bus ();

    dm_cache_ctrl #(.INDEX_BITS(6)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] cpu_exp_q[$];
    mexp_t       mem_exp_q[$];

    // reference: CPU-visible memory, memory-side copy, line bookkeeping
    logic [31:0] ref_mem[int];
    logic [31:0] ref_bak[int];
    bit          ref_valid[64];
    bit          ref_dirty[64];
    int          ref_tag[64];

    logic [31:0] env_mem[int];
    int          fixed_delay = -1;
    bit          resp_block  = 1'b0;
    bit          stale_req   = 1'b0;
    int          rsp_d;
    logic [26:0] rsp_addr;
    logic        rsp_rw;
    logic [127:0] rsp_data;
    logic [127:0] rsp_line;

    bit          prev_valid = 1'b0;
    logic [26:0] prev_addr;
    logic        prev_rw;
    logic [127:0] prev_data;
    int          run_len  = 0;
    int          last_run = 0;
    int          mem_txn_cnt = 0;
    bit          timed_out = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [31:0] init_word(input int w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] env_rd(input int w);
        return env_mem.exists(w) ? env_mem[w] : init_word(w);
    endfunction

    function automatic void model_predict(input logic [26:0] a, input logic [31:0] d, input logic rw);
        int    idx, tag, w, vb;
        mexp_t m;
        idx = (int'(a) >> 4) & 63;
        tag = int'(a) >> 10;
        w   = int'(a) >> 2;
        if (!(ref_valid[idx] && ref_tag[idx] == tag)) begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                vb     = (ref_tag[idx] << 8) | (idx << 2);
                m.addr = 27'((ref_tag[idx] << 10) | (idx << 4));
                m.rw   = 1'b1;
                m.data = '0;
                for (int k = 0; k < 4; k++) begin
                    m.data[32*k +: 32] = ref_rd(vb + k);
                    ref_bak[vb + k]    = ref_rd(vb + k);
                end
                mem_exp_q.push_back(m);
            end
            m.addr = 27'(int'(a) & ~15);
            m.rw   = 1'b0;
            m.data = '0;
            mem_exp_q.push_back(m);
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
            ref_dirty[idx] = 1'b0;
        end
        if (rw) begin
            ref_mem[w]     = d;
            ref_dirty[idx] = 1'b1;
            cpu_exp_q.push_back(32'h0);
        end else begin
            cpu_exp_q.push_back(ref_rd(w));
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
        ref_mem = ref_bak;
    endfunction

    task automatic issue(input logic [26:0] a, input logic [31:0] d, input logic rw,
                         input bit keep, input bit scramble, output int lat);
        bit got;
        got = 1'b0;
        model_predict(a, d, rw);
        @(negedge sys_clk);
        bus.cpu_req_addr  = a;
        bus.cpu_req_data  = d;
        bus.cpu_req_rw    = rw;
        bus.cpu_req_valid = 1'b1;
        lat = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge sys_clk);
            #1;
            lat++;
            if (bus.cpu_res_ready) got = 1'b1;
            else if (scramble) begin
                bus.cpu_req_addr = 27'($urandom);
                bus.cpu_req_data = $urandom;
                bus.cpu_req_rw   = 1'($urandom_range(0, 1));
            end
        end
        if (!got) begin
            fail_now("cpu_timeout", $sformatf("no cpu_res_ready for addr %0h", a));
            timed_out = 1'b1;
        end
        if (!keep) begin
            @(negedge sys_clk);
            bus.cpu_req_valid = 1'b0;
        end
    endtask

    // memory responder
    initial begin
        bus.mem_res_ready = 1'b0;
        bus.mem_res_data  = '0;
        forever begin
            @(negedge sys_clk);
            if (stale_req) begin
                bus.mem_res_data  = {4{32'hDEAD_BEEF}};
                bus.mem_res_ready = 1'b1;
                @(negedge sys_clk);
                bus.mem_res_ready = 1'b0;
                stale_req = 1'b0;
            end else if (bus.mem_req_valid && !resp_block) begin
                rsp_addr = bus.mem_req_addr;
                rsp_rw   = bus.mem_req_rw;
                rsp_data = bus.mem_req_data;
                rsp_d    = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
                repeat (rsp_d) @(negedge sys_clk);
                if (rsp_rw) begin
                    for (int k = 0; k < 4; k++)
                        env_mem[(int'(rsp_addr) >> 2) + k] = rsp_data[32*k +: 32];
                end else begin
                    for (int k = 0; k < 4; k++)
                        rsp_line[32*k +: 32] = env_rd((int'(rsp_addr) >> 2) + k);
                    bus.mem_res_data = rsp_line;
                end
                bus.mem_res_ready = 1'b1;
                @(negedge sys_clk);
                bus.mem_res_ready = 1'b0;
            end
        end
    end

    // monitor: CPU responses and memory requests
    initial begin
        logic [31:0] ce;
        mexp_t       me;
        forever begin
            @(posedge sys_clk);
            #1;
            if (bus.cpu_res_ready) begin
                if (cpu_exp_q.size() == 0)
                    fail_now("cpu_unexpected_ready", $sformatf("data=%0h", bus.cpu_res_data));
                else begin
                    ce = cpu_exp_q.pop_front();
                    check("cpu_res_data", bus.cpu_res_data, ce);
                end
            end else begin
                check("cpu_data_zero_when_idle", bus.cpu_res_data, 32'h0);
            end

            if (prev_valid && bus.mem_res_ready)
                check("mem_valid_fall_after_ready", bus.mem_req_valid, 1'b0);

            if (bus.mem_req_valid && !prev_valid) begin
                mem_txn_cnt++;
                run_len = 1;
                if (mem_exp_q.size() == 0)
                    fail_now("mem_unexpected_req", $sformatf("addr=%0h rw=%0b", bus.mem_req_addr, bus.mem_req_rw));
                else begin
                    me = mem_exp_q.pop_front();
                    check("mem_req_addr", bus.mem_req_addr, me.addr);
                    check("mem_req_rw", bus.mem_req_rw, me.rw);
                    if (me.rw) check("mem_wb_data", bus.mem_req_data, me.data);
                end
            end else if (bus.mem_req_valid && prev_valid) begin
                run_len++;
                check("mem_addr_stable", bus.mem_req_addr, prev_addr);
                check("mem_rw_stable", bus.mem_req_rw, prev_rw);
                check("mem_data_stable", bus.mem_req_data, prev_data);
            end
            if (!bus.mem_req_valid && prev_valid) last_run = run_len;

            prev_valid = bus.mem_req_valid;
            prev_addr  = bus.mem_req_addr;
            prev_rw    = bus.mem_req_rw;
            prev_data  = bus.mem_req_data;
        end
    end

    // stimulus
    initial begin
        int lat, lat2, m0;
        bit seen;
        bus.cpu_req_addr  = '0;
        bus.cpu_req_data  = '0;
        bus.cpu_req_rw    = 1'b0;
        bus.cpu_req_valid = 1'b0;
        model_reset();

        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_cpu_res_ready", bus.cpu_res_ready, 1'b0);
        check("rst_cpu_res_data", bus.cpu_res_data, 32'h0);
        check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
        check("rst_mem_req_rw", bus.mem_req_rw, 1'b0);
        check("rst_mem_req_addr", bus.mem_req_addr, 27'h0);
        check("rst_mem_req_data", bus.mem_req_data, 128'h0);
        check("rst_valid_bits", dut.u_array.valid_q, 64'h0);
        check("rst_dirty_bits", dut.u_array.dirty_q, 64'h0);
        @(negedge sys_clk);
        rst = 1'b1;

        // cold write allocates line 42, then dirties word 2
        issue(27'h2AAAAAA, 32'h3333_3333, 1'b1, 1'b0, 1'b0, lat);
        check("cold_write_dirty42", dut.u_array.dirty_q[42], 1'b1);
        check("cold_write_word2", dut.u_array.data_mem[42][95:64], 32'h3333_3333);

        // read hit: 2-cycle latency, no memory traffic
        m0 = mem_txn_cnt;
        issue(27'h2AAAAAA, 32'h0, 1'b0, 1'b0, 1'b0, lat);
        check("hit_latency", lat, 2);
        check("hit_no_mem_req", mem_txn_cnt, m0);

        // conflicting read: write-back of dirty victim, then fill
        issue(27'h2AAAEAA, 32'h0, 1'b0, 1'b0, 1'b0, lat);

        // clean miss with a slow memory
        fixed_delay = 20;
        m0 = mem_txn_cnt;
        issue(27'h0000054, 32'h0, 1'b0, 1'b0, 1'b0, lat);
        check("slow_fill_one_txn", mem_txn_cnt, m0 + 1);
        check("slow_fill_held", (last_run >= 20), 1'b1);
        fixed_delay = -1;

        // back-to-back hits with valid held across the pulse
        issue(27'h2AAAEAA, 32'h0, 1'b0, 1'b1, 1'b0, lat);
        issue(27'h2AAAEA4, 32'h0, 1'b0, 1'b0, 1'b0, lat2);
        check("b2b_first_latency", lat, 2);
        check("b2b_second_latency", lat2, 3);

        // reset while a fill is outstanding
        resp_block = 1'b1;
        model_predict(27'h0000040, 32'h0, 1'b0);
        @(negedge sys_clk);
        bus.cpu_req_addr  = 27'h0000040;
        bus.cpu_req_rw    = 1'b0;
        bus.cpu_req_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge sys_clk);
            #1;
            if (bus.mem_req_valid && !bus.mem_req_rw) seen = 1'b1;
        end
        if (!seen) fail_now("alloc_not_reached", "no fill request before reset");
        @(negedge sys_clk);
        rst = 1'b0;
        bus.cpu_req_valid = 1'b0;
        #1;
        check("midrst_mem_req_valid", bus.mem_req_valid, 1'b0);
        check("midrst_mem_req_addr", bus.mem_req_addr, 27'h0);
        check("midrst_cpu_res_ready", bus.cpu_res_ready, 1'b0);
        check("midrst_valid_bits", dut.u_array.valid_q, 64'h0);
        cpu_exp_q.delete();
        model_reset();
        repeat (2) @(negedge sys_clk);
        rst = 1'b1;
        resp_block = 1'b0;
        stale_req  = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("stale_ready_ignored_valid", bus.mem_req_valid, 1'b0);
        m0 = mem_txn_cnt;
        issue(27'h0000040, 32'h0, 1'b0, 1'b0, 1'b0, lat);
        check("post_reset_fresh_miss", mem_txn_cnt, m0 + 1);

        // randomized traffic over a few tags and indices
        for (int n = 0; n < 300 && !timed_out; n++) begin
            logic [26:0] a;
            a = {17'($urandom_range(0, 2)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3))};
            issue(a, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1, lat);
        end

        repeat (5) @(negedge sys_clk);
        check("cpu_queue_drained", cpu_exp_q.size(), 0);
        check("mem_queue_drained", mem_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_cache_ctrl.md
DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, meaning number of line-index bits (2**INDEX_BITS lines).
REQ-002 SHALL have these ports, with one clock; reset is asynchronous and active-low:
- sys_clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req_addr  in  27  byte address; bits [1:0] ignored.
- cpu_req_data  in  32  write data.
- cpu_req_rw  in  1  1=write, 0=read.
- cpu_req_valid  in  1  request present.
- cpu_res_data  out  32  read data.
- cpu_res_ready  out  1  one-cycle completion pulse.
- mem_req_addr  out  27  line-aligned address, bits [3:0]=0.
- mem_req_data  out  128  write-back line.
- mem_req_rw  out  1  1=write-back, 0=fill.
- mem_req_valid  out  1  memory request present.
- mem_res_data  in  128  fill line.
- mem_res_ready  in  1  memory completion pulse.

Function
REQ-003 SHALL implement a direct-mapped, write-back, write-allocate cache with 16-byte (4-word) lines.
REQ-004 SHALL decode the address as offset [3:2] word select, index [INDEX_BITS+3:4], tag [26:INDEX_BITS+4] (17 bits at default).
REQ-005 SHALL keep one valid bit, one dirty bit, one tag and one 128-bit data entry per line.
REQ-006 SHALL use states IDLE, COMPARE, WRITE_BACK and ALLOCATE.
REQ-007 In IDLE, when cpu_req_valid=1, SHALL latch addr/data/rw and go to COMPARE; otherwise it SHALL stay in IDLE.
REQ-008 In COMPARE, a hit (valid and tag equal) SHALL pulse cpu_res_ready for that cycle and return to IDLE, giving 2-cycle hit latency from the sampling edge.
REQ-009 A read hit SHALL drive cpu_res_data with the selected word in the cycle cpu_res_ready=1.
REQ-010 A write hit SHALL replace only the selected word and set dirty=1.
REQ-011 cpu_res_data SHALL be 0 whenever cpu_res_ready=0.
REQ-012 Miss handling in COMPARE:
- victim valid and dirty: go to WRITE_BACK.
- otherwise: go to ALLOCATE.
REQ-013 In WRITE_BACK, SHALL drive mem_req_valid=1, rw=1, addr={victim tag, index, 4'b0}, data=victim line until mem_res_ready=1, then go to ALLOCATE.
REQ-014 In ALLOCATE, SHALL drive mem_req_valid=1, rw=0, addr={req tag, index, 4'b0} until mem_res_ready=1.
REQ-015 On that ALLOCATE completion, SHALL write mem_res_data with valid=1, dirty=0 and the new tag, then return to COMPARE, which then hits.
REQ-016 mem_req_valid SHALL fall in the cycle after mem_res_ready is sampled.
REQ-017 mem_req_* SHALL hold stable while mem_req_valid=1; mem_req_valid SHALL be 0 in IDLE/COMPARE.
REQ-018 The CPU holds its request until cpu_res_ready; a valid still high in the IDLE cycle after a pulse SHALL be accepted as a new request.
REQ-019 cpu_req_* changes after latching SHALL NOT affect the in-flight request.
REQ-020 mem_res_ready outside WRITE_BACK/ALLOCATE SHALL be ignored.

Reset
REQ-021 rst=0 SHALL immediately force:
- state to IDLE;
- all valid and dirty bits to 0;
- cpu_res_ready, mem_req_valid, mem_req_rw to 0;
- cpu_res_data, mem_req_addr, mem_req_data to 0.
REQ-022 Tag and data arrays need no reset.
REQ-023 Reset mid-miss SHALL abandon the transfer and discard any subsequent mem_res_ready.

Structure
REQ-024 Package cache_pkg SHALL hold:
- cpu_req_t and cpu_result_t structs;
- mem_req_t struct and mem_data_t (128-bit);
- the cache_state_t enum;
- the LINE_BYTES=16 and WORDS_PER_LINE=4 constants.
REQ-025 The data/tag storage SHALL be one sub-module cache_data_array: synchronous write, combinational read, indexed by INDEX_BITS.

Verification
REQ-026 Cold write to 0x2AAAAAA with 0x33333333 -> ALLOCATE fill from 0x2AAAAA0, then cpu_res_ready pulse; line 42 word 2 dirty=1.
REQ-027 Read of 0x2AAAAAA after REQ-026 -> hit, cpu_res_data=0x33333333 exactly 2 cycles after the sampling edge, no mem_req_valid.
REQ-028 Read of 0x2AAAEAA (same index 42, tag 0xAAAB) after REQ-026 -> WRITE_BACK to 0x2AAAAA0 with word 2=0x33333333, then fill from 0x2AAAEA0, then ready.
REQ-029 Clean miss -> no WRITE_BACK; mem_res_ready delayed 20 cycles -> mem_req_valid held with stable addr for all 20 cycles.
REQ-030 rst asserted during ALLOCATE, then a read of the same address -> fresh miss (valid cleared); the stale mem_res_ready is ignored.
REQ-031 Back-to-back reads with cpu_req_valid held high across the pulse -> second request accepted in the following IDLE cycle.
